// File: rtl/fb_axi_clear.sv
// Framebuffer clear sequencer: fills h_pixels*v_pixels beats with one colour using
// single-outstanding AXI4 INCR bursts. Define FB_AXI_CLEAR_ERR_EN to abort on a bad bresp.
module fb_axi_clear #(
  parameter int AXI_ADDR_WIDTH = 21,
  parameter int AXI_DATA_WIDTH = 16,
  parameter int AXI_ID_WIDTH   = 6,
  parameter int AXI_ID         = 0,
  parameter int H_WIDTH        = 12,
  parameter int V_WIDTH        = 12,
  parameter int BURST_LEN      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [H_WIDTH-1:0]            h_pixels,
  input  logic [V_WIDTH-1:0]            v_pixels,
  input  logic [AXI_DATA_WIDTH-1:0]     color,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,
  output logic [AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [AXI_ID_WIDTH-1:0]       m_axi_awid,
  output logic [7:0]                    m_axi_awlen,
  output logic [2:0]                    m_axi_awsize,
  output logic [1:0]                    m_axi_awburst,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,
  output logic [AXI_DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                          m_axi_wlast,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready,
  input  logic [AXI_ID_WIDTH-1:0]       m_axi_bid,
  input  logic [1:0]                    m_axi_bresp
);

  localparam int CW = H_WIDTH + V_WIDTH;
  localparam int SZ = $clog2(AXI_DATA_WIDTH / 8);
  localparam logic [CW-1:0] BL_CW = CW'(BURST_LEN);
  localparam logic [8:0]    BL_N  = 9'(BURST_LEN);

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_RESP, S_DONE} state_t;

  state_t                    state_q, state_d;
  logic [CW-1:0]             total_q, total_d;
  logic [CW-1:0]             index_q, index_d;
  logic [AXI_DATA_WIDTH-1:0] color_q, color_d;
  logic                      err_q, err_d;
  logic [8:0]                n_q, n_d;
  logic [8:0]                beat_q, beat_d;
  logic                      awvalid_q, awvalid_d;
  logic                      wvalid_q, wvalid_d;
  logic                      wlast_q, wlast_d;
  logic                      aw_done_q, aw_done_d;
  logic                      w_done_q, w_done_d;
  logic [AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [7:0]                awlen_q, awlen_d;

  logic [CW-1:0]             prod, index_inc, setup_idx, setup_tot, remaining;
  logic [8:0]                setup_n;
  logic [AXI_ADDR_WIDTH-1:0] setup_addr;
  logic                      aw_hs, w_hs, b_hs, aw_fin, w_fin, last_burst, resp_err;
  logic                      start_go, load_burst;
  logic                      bid_unused;

  assign bid_unused = ^m_axi_bid;

`ifdef FB_AXI_CLEAR_ERR_EN
  assign resp_err = (m_axi_bresp != 2'b00);
`else
  logic bresp_unused;
  assign bresp_unused = ^m_axi_bresp;
  assign resp_err     = 1'b0;
`endif

  assign prod       = CW'(h_pixels) * CW'(v_pixels);
  assign index_inc  = index_q + CW'(n_q);
  assign last_burst = (index_inc == total_q);

  assign aw_hs  = awvalid_q & m_axi_awready;
  assign w_hs   = wvalid_q & m_axi_wready;
  assign b_hs   = (state_q == S_RESP) & m_axi_bvalid;
  assign aw_fin = aw_done_q | aw_hs;
  assign w_fin  = w_done_q | (w_hs & wlast_q);

  // Next burst is set up either from a fresh start (index 0) or after a B handshake.
  assign setup_idx  = (state_q == S_IDLE) ? '0 : index_inc;
  assign setup_tot  = (state_q == S_IDLE) ? prod : total_q;
  assign remaining  = setup_tot - setup_idx;
  assign setup_n    = (remaining >= BL_CW) ? BL_N : remaining[8:0];
  assign setup_addr = AXI_ADDR_WIDTH'((AXI_ADDR_WIDTH + CW)'(setup_idx) << SZ);

  assign start_go   = (state_q == S_IDLE) & start & (prod != '0);
  assign load_burst = start_go | (b_hs & ~resp_err & ~last_burst);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      total_q   <= '0;
      index_q   <= '0;
      color_q   <= '0;
      err_q     <= 1'b0;
      n_q       <= '0;
      beat_q    <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      wlast_q   <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      awaddr_q  <= '0;
      awlen_q   <= '0;
    end else begin
      state_q   <= state_d;
      total_q   <= total_d;
      index_q   <= index_d;
      color_q   <= color_d;
      err_q     <= err_d;
      n_q       <= n_d;
      beat_q    <= beat_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      wlast_q   <= wlast_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      awaddr_q  <= awaddr_d;
      awlen_q   <= awlen_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (prod == '0) ? S_DONE : S_BURST;
      S_BURST: if (aw_fin && w_fin) state_d = S_RESP;
      S_RESP:  if (b_hs) state_d = (resp_err || last_burst) ? S_DONE : S_BURST;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    total_d   = total_q;
    index_d   = index_q;
    color_d   = color_q;
    err_d     = err_q;
    n_d       = n_q;
    beat_d    = beat_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    wlast_d   = wlast_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    awaddr_d  = awaddr_q;
    awlen_d   = awlen_q;

    if (state_q == S_IDLE && start) begin
      total_d = prod;
      index_d = '0;
      color_d = color;
      err_d   = 1'b0;
    end

    if (state_q == S_BURST) begin
      if (aw_hs) begin
        awvalid_d = 1'b0;
        aw_done_d = 1'b1;
      end
      if (w_hs) begin
        if (wlast_q) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
          wlast_d  = 1'b0;
        end else begin
          beat_d  = beat_q + 9'd1;
          wlast_d = ((beat_q + 9'd2) == n_q);
        end
      end
    end

    if (b_hs) begin
      index_d = index_inc;
      if (resp_err) err_d = 1'b1;
    end

    if (load_burst) begin
      awvalid_d = 1'b1;
      wvalid_d  = 1'b1;
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
      n_d       = setup_n;
      beat_d    = '0;
      wlast_d   = (setup_n == 9'd1);
      awaddr_d  = setup_addr;
      awlen_d   = 8'(setup_n - 9'd1);
    end
  end

  always_comb begin
    busy         = (state_q == S_BURST) || (state_q == S_RESP);
    done         = (state_q == S_DONE);
    m_axi_bready = (state_q == S_RESP);
  end

  assign err           = err_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awid    = AXI_ID_WIDTH'(AXI_ID);
  assign m_axi_awlen   = awlen_q;
  assign m_axi_awsize  = 3'(SZ);
  assign m_axi_awburst = 2'b01;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_wdata   = color_q;
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = wlast_q;

endmodule

// File: tb/tb_fb_axi_clear.sv
// Scoreboard bench for fb_axi_clear with BURST_LEN=4: directed clears push expected
// AW/W/done records, a negedge monitor pops and compares them against the AXI traffic.
module tb_fb_axi_clear;
  localparam int AW = 21, DW = 16, IW = 6, HW = 12, VW = 12, BL = 4;

  logic clk, rst_n, start;
  logic [HW-1:0] h_pixels;
  logic [VW-1:0] v_pixels;
  logic [DW-1:0] color;
  logic busy, done, err;
  logic m_axi_awvalid, m_axi_awready;
  logic [AW-1:0] m_axi_awaddr;
  logic [IW-1:0] m_axi_awid;
  logic [7:0] m_axi_awlen;
  logic [2:0] m_axi_awsize;
  logic [1:0] m_axi_awburst;
  logic m_axi_wvalid, m_axi_wready;
  logic [DW-1:0] m_axi_wdata;
  logic [DW/8-1:0] m_axi_wstrb;
  logic m_axi_wlast, m_axi_bvalid, m_axi_bready;
  logic [IW-1:0] m_axi_bid;
  logic [1:0] m_axi_bresp;

  fb_axi_clear #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW), .AXI_ID(0),
                 .H_WIDTH(HW), .V_WIDTH(VW), .BURST_LEN(BL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .h_pixels(h_pixels), .v_pixels(v_pixels),
    .color(color), .busy(busy), .done(done), .err(err),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready), .m_axi_awaddr(m_axi_awaddr),
    .m_axi_awid(m_axi_awid), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bid(m_axi_bid),
    .m_axi_bresp(m_axi_bresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] addr; logic [7:0] len; } aw_t;
  typedef struct { logic [DW-1:0] data; logic last; } w_t;
  aw_t aw_q[$];
  w_t  w_q[$];
  int  done_exp = 0;
  int  done_cnt = 0;
  int  n_checks = 0;
  int  n_fails  = 0;

  // Responder knobs
  int  aw_delay = 0, b_delay = 0, err_burst = -1, b_count = 0;
  bit  w_toggle = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_aw(input logic [AW-1:0] a, input logic [7:0] l);
    aw_t e;
    e.addr = a; e.len = l;
    aw_q.push_back(e);
  endtask

  task automatic push_w(input logic [DW-1:0] d, input int beats);
    w_t e;
    for (int i = 0; i < beats; i++) begin
      e.data = d; e.last = (i == beats - 1);
      w_q.push_back(e);
    end
  endtask

  task automatic start_clear(input logic [HW-1:0] h, input logic [VW-1:0] v, input logic [DW-1:0] c);
    @(posedge clk); #1;
    start = 1'b1; h_pixels = h; v_pixels = v; color = c;
    @(posedge clk); #1;
    start = 1'b0;
    $display("start h=%0d v=%0d color=0x%0h", h, v, c);
  endtask

  task automatic wait_done();
    int c0, k;
    c0 = done_cnt; k = 0;
    while (done_cnt == c0 && k < 1000) begin
      @(negedge clk); #1;
      k++;
    end
    check("done_timeout", 64'(done_cnt != c0), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valids"}, {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_wlast}, 0);
    check({tag, "_status"}, {busy, done, err}, 0);
    check({tag, "_awaddr"}, 64'(m_axi_awaddr), 0);
    check({tag, "_awlen"}, 64'(m_axi_awlen), 0);
  endtask

  // AXI slave responder
  initial begin
    int aw_cnt, b_cnt;
    bit b_hs_s;
    aw_cnt = 0; b_cnt = 0;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0; m_axi_bid = 0;
    forever begin
      @(negedge clk);
      b_hs_s = m_axi_bvalid && m_axi_bready;
      @(posedge clk); #1;
      if (!rst_n) begin
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
        aw_cnt = 0; b_cnt = 0;
      end else begin
        if (m_axi_awvalid) begin
          if (aw_cnt >= aw_delay) m_axi_awready = 1'b1;
          else begin m_axi_awready = 1'b0; aw_cnt++; end
        end else begin
          m_axi_awready = 1'b0; aw_cnt = 0;
        end
        m_axi_wready = w_toggle ? ~m_axi_wready : 1'b1;
        if (b_hs_s) begin
          m_axi_bvalid = 1'b0; b_cnt = 0; b_count++;
        end else if (!m_axi_bvalid && m_axi_bready) begin
          if (b_cnt >= b_delay) begin
            m_axi_bvalid = 1'b1;
            m_axi_bresp  = (b_count == err_burst) ? 2'b10 : 2'b00;
          end else b_cnt++;
        end
      end
    end
  end

  // Monitor: pops expectations on every handshake and checks hold-stability
  initial begin
    bit aw_pend, w_pend, outstanding;
    logic [AW-1:0] s_addr;
    logic [7:0] s_len;
    logic [DW-1:0] s_data;
    logic s_last;
    aw_t ea;
    w_t ew;
    aw_pend = 0; w_pend = 0; outstanding = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        aw_pend = 0; w_pend = 0; outstanding = 0;
      end else begin
        if (done) begin
          check("done_not_busy", 64'(busy), 0);
          check("done_expected", 64'(done_exp > 0), 1);
          if (done_exp > 0) done_exp--;
          done_cnt++;
          $display("done pulse, err=%0b", err);
        end
        if (aw_pend) check("aw_hold", {m_axi_awvalid, m_axi_awaddr, m_axi_awlen}, {1'b1, s_addr, s_len});
        if (w_pend) check("w_hold", {m_axi_wvalid, m_axi_wdata, m_axi_wlast}, {1'b1, s_data, s_last});
        if (m_axi_awvalid && m_axi_awready) begin
          check("aw_single_outstanding", 64'(outstanding), 0);
          outstanding = 1;
          check("aw_expected", 64'(aw_q.size() != 0), 1);
          if (aw_q.size() != 0) begin
            ea = aw_q.pop_front();
            check("awaddr", 64'(m_axi_awaddr), 64'(ea.addr));
            check("awlen", 64'(m_axi_awlen), 64'(ea.len));
            check("aw_fixed", {m_axi_awid, m_axi_awsize, m_axi_awburst}, {6'd0, 3'd1, 2'b01});
          end
          $display("AW addr=0x%0h len=%0d", m_axi_awaddr, m_axi_awlen);
        end
        if (m_axi_wvalid && m_axi_wready) begin
          check("w_expected", 64'(w_q.size() != 0), 1);
          if (w_q.size() != 0) begin
            ew = w_q.pop_front();
            check("wdata", 64'(m_axi_wdata), 64'(ew.data));
            check("wlast", 64'(m_axi_wlast), 64'(ew.last));
            check("wstrb", 64'(m_axi_wstrb), 64'd3);
          end
          $display("W data=0x%0h last=%0b", m_axi_wdata, m_axi_wlast);
        end
        if (m_axi_bvalid && m_axi_bready) begin
          outstanding = 0;
          $display("B resp=%0b", m_axi_bresp);
        end
        aw_pend = m_axi_awvalid && !m_axi_awready;
        s_addr = m_axi_awaddr; s_len = m_axi_awlen;
        w_pend = m_axi_wvalid && !m_axi_wready;
        s_data = m_axi_wdata; s_last = m_axi_wlast;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    w_t wb;
    rst_n = 0; start = 0; h_pixels = 0; v_pixels = 0; color = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1;

    // Basic two-burst clear
    push_aw(21'h0, 8'd3); push_w(16'hF0F0, 4);
    push_aw(21'h8, 8'd3); push_w(16'hF0F0, 4);
    done_exp++;
    start_clear(12'd4, 12'd2, 16'hF0F0);
    check("t1_latency", {busy, m_axi_awvalid, m_axi_wvalid, done}, 4'b1110);
    wait_done();
    check("t1_err", 64'(err), 0);

    // Short final burst
    push_aw(21'h0, 8'd3); push_w(16'h1234, 4);
    push_aw(21'h8, 8'd0); push_w(16'h1234, 1);
    done_exp++;
    start_clear(12'd5, 12'd1, 16'h1234);
    wait_done();

    // Backpressure
    aw_delay = 5; w_toggle = 1; b_delay = 3;
    push_aw(21'h0, 8'd3); push_w(16'hA5A5, 4);
    push_aw(21'h8, 8'd3); push_w(16'hA5A5, 4);
    done_exp++;
    start_clear(12'd8, 12'd1, 16'hA5A5);
    wait_done();
    aw_delay = 0; w_toggle = 0; b_delay = 0;
    repeat (2) @(posedge clk);

    // Zero size
    done_exp++;
    start_clear(12'd0, 12'd7, 16'hBEEF);
    check("t4_zero_t1", {busy, done, m_axi_awvalid, m_axi_wvalid}, 4'b0100);
    wait_done();
    @(posedge clk); #1;
    check("t4_zero_t2", {busy, done, m_axi_awvalid, m_axi_wvalid}, 4'b0000);

    // Start while busy is ignored
    push_aw(21'h0, 8'd3);  push_w(16'h0F0F, 4);
    push_aw(21'h8, 8'd3);  push_w(16'h0F0F, 4);
    push_aw(21'h10, 8'd0); push_w(16'h0F0F, 1);
    done_exp++;
    start_clear(12'd3, 12'd3, 16'h0F0F);
    @(posedge clk); #1;
    start = 1; h_pixels = 12'd1; v_pixels = 12'd1; color = 16'hFFFF;
    @(posedge clk); #1;
    start = 0;
    wait_done();
    repeat (5) @(posedge clk);

`ifdef FB_AXI_CLEAR_ERR_EN
    // Error on first burst of a 3-burst clear aborts it
    err_burst = b_count;
    push_aw(21'h0, 8'd3); push_w(16'hC3C3, 4);
    done_exp++;
    start_clear(12'd6, 12'd2, 16'hC3C3);
    wait_done();
    check("t6_err_set", 64'(err), 1);
    err_burst = -1;
    repeat (4) @(posedge clk);
    #1;
    check("t6_err_sticky", 64'(err), 1);
    push_aw(21'h0, 8'd0); push_w(16'h0001, 1);
    done_exp++;
    start_clear(12'd1, 12'd1, 16'h0001);
    check("t6_err_cleared", 64'(err), 0);
    wait_done();
`else
    // bresp is ignored: every burst issues and err stays low
    err_burst = b_count;
    push_aw(21'h0, 8'd3); push_w(16'hC3C3, 4);
    push_aw(21'h8, 8'd3); push_w(16'hC3C3, 4);
    push_aw(21'h10, 8'd3); push_w(16'hC3C3, 4);
    done_exp++;
    start_clear(12'd6, 12'd2, 16'hC3C3);
    wait_done();
    check("t6_err_ignored", 64'(err), 0);
    err_burst = -1;
`endif

    // Reset mid-operation: only the AW and first beat land before reset
    push_aw(21'h0, 8'd3);
    wb.data = 16'h7777; wb.last = 1'b0; w_q.push_back(wb);
    start_clear(12'd16, 12'd4, 16'h7777);
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    repeat (10) @(posedge clk);
    #1;
    check("midreset_no_done", 64'(done_exp), 0);
    check("midreset_idle", {busy, m_axi_awvalid, m_axi_wvalid}, 3'b000);

    // Normal operation after reset
    push_aw(21'h0, 8'd1); push_w(16'h5A5A, 2);
    done_exp++;
    start_clear(12'd2, 12'd1, 16'h5A5A);
    wait_done();
    repeat (3) @(posedge clk);
    #1;
    check("aw_queue_drained", 64'(aw_q.size()), 0);
    check("w_queue_drained", 64'(w_q.size()), 0);
    check("done_drained", 64'(done_exp), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
